mul_fp_vec_pipe: RTL and testbench



---
 rtl/mul_fp_vec_pipe.sv | 177 +++++++++++++++++
 tb/tb_mul_fp_vec_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_fp_vec_pipe.sv
// mul_fp_vec_pipe
// Three-stage pipelined, multi-lane minifloat multiplier. Each lane decodes two
// sign/exponent/mantissa operands (no bias, no inf/NaN, e=0 is subnormal) and
// produces the exact signed fixed-point product. The lane products and their
// sign-extended sum are presented together behind a valid/ready handshake.
//
// Optional feature macro: MUL_FP_VEC_PIPE_FTZ_EN
//   defined   -> operands with e=0 are flushed to zero before the first stage
//   undefined -> subnormal operands are multiplied exactly
//
// Ports
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_valid  operand vector valid
//   o_ready  operands accepted this cycle (combinational through the stall chain)
//   i_op0    operand A, lane k at [k*BIT_W +: BIT_W]
//   i_op1    operand B, same packing
//   o_valid  result valid
//   i_ready  downstream accepts result
//   o_prd    signed per-lane products, lane k at [k*PRD_W +: PRD_W]
//   o_sum    signed sum of all lane products
module mul_fp_vec_pipe #(
    parameter int  EXP_W = 4,
    parameter int  MAN_W = 3,
    parameter int  LANES = 4,
    localparam int BIT_W = 1 + EXP_W + MAN_W,
    localparam int PRD_W = 2 * ((1 << EXP_W) + MAN_W + 2),
    localparam int SUM_W = PRD_W + $clog2(LANES) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [LANES*BIT_W-1:0] i_op0,
    input  logic [LANES*BIT_W-1:0] i_op1,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [LANES*PRD_W-1:0] o_prd,
    output logic [SUM_W-1:0]       o_sum
);

    // signed significand {sign, nrm, m}, shift amount and raw product widths
    localparam int SIG_W = MAN_W + 2;
    localparam int SH_W  = EXP_W + 1;
    localparam int MUL_W = 2 * SIG_W;

    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

    // Signed significand of one operand; a flushed subnormal yields zero.
    function automatic logic signed [SIG_W-1:0] op_sig(input logic [BIT_W-1:0] op);
        logic             nrm;
        logic [SIG_W-1:0] mag;
        nrm = |op[MAN_W +: EXP_W];
`ifdef MUL_FP_VEC_PIPE_FTZ_EN
        if (nrm) begin
            mag = {1'b0, 1'b1, op[MAN_W-1:0]};
        end else begin
            mag = '0;
        end
`else
        mag = {1'b0, nrm, op[MAN_W-1:0]};
`endif
        if (op[BIT_W-1]) begin
            return $signed(-mag);
        end else begin
            return $signed(mag);
        end
    endfunction

    // Effective exponent e - nrm; subnormals share the weight of e=1.
    function automatic logic [SH_W-1:0] op_exp(input logic [BIT_W-1:0] op);
        logic [EXP_W-1:0] e;
        e = op[MAN_W +: EXP_W];
        if (|e) begin
            return {1'b0, e - EXP_ONE};
        end else begin
            return '0;
        end
    endfunction

    logic                    s1_v_r, s2_v_r, s3_v_r;
    logic                    s1_en_s, s2_en_s, s3_en_s;
    logic signed [SIG_W-1:0] s1_sig0_r [LANES];
    logic signed [SIG_W-1:0] s1_sig1_r [LANES];
    logic [SH_W-1:0]         s1_sh_r   [LANES];
    logic signed [MUL_W-1:0] mul_s     [LANES];
    logic signed [PRD_W-1:0] shf_s     [LANES];
    logic signed [PRD_W-1:0] s2_prd_r  [LANES];
    logic [SUM_W-1:0]        sum_s;
    logic [LANES*PRD_W-1:0]  s3_prd_r;
    logic [SUM_W-1:0]        s3_sum_r;

    // Stall chain: a stage may load when empty or when the next stage takes its contents.
    always_comb begin
        s3_en_s = !s3_v_r || i_ready;
        s2_en_s = !s2_v_r || s3_en_s;
        s1_en_s = !s1_v_r || s2_en_s;
    end

    assign o_ready = s1_en_s;
    assign o_valid = s3_v_r;
    assign o_prd   = s3_prd_r;
    assign o_sum   = s3_sum_r;

    // Significand product sign-extended to the product width, then placed by the exponent sum.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            mul_s[k] = s1_sig0_r[k] * s1_sig1_r[k];
            shf_s[k] = {{(PRD_W-MUL_W){mul_s[k][MUL_W-1]}}, mul_s[k]} << s1_sh_r[k];
        end
    end

    // Adder tree over the S2 products, each sign-extended to the sum width.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_s = sum_s + {{(SUM_W-PRD_W){s2_prd_r[k][PRD_W-1]}}, s2_prd_r[k]};
        end
    end

    // Stage valid bits advance whenever their stage is enabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_v_r <= 1'b0;
            s2_v_r <= 1'b0;
            s3_v_r <= 1'b0;
        end else begin
            if (s1_en_s) s1_v_r <= i_valid;
            if (s2_en_s) s2_v_r <= s1_v_r;
            if (s3_en_s) s3_v_r <= s2_v_r;
        end
    end

    // S1: decoded significands and shift; payload is sampled only on an input transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                s1_sig0_r[k] <= '0;
                s1_sig1_r[k] <= '0;
                s1_sh_r[k]   <= '0;
            end
        end else if (s1_en_s && i_valid) begin
            for (int k = 0; k < LANES; k++) begin
                s1_sig0_r[k] <= op_sig(i_op0[k*BIT_W +: BIT_W]);
                s1_sig1_r[k] <= op_sig(i_op1[k*BIT_W +: BIT_W]);
                s1_sh_r[k]   <= op_exp(i_op0[k*BIT_W +: BIT_W]) + op_exp(i_op1[k*BIT_W +: BIT_W]);
            end
        end
    end

    // S2: shifted signed products.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                s2_prd_r[k] <= '0;
            end
        end else if (s2_en_s && s1_v_r) begin
            for (int k = 0; k < LANES; k++) begin
                s2_prd_r[k] <= shf_s[k];
            end
        end
    end

    // S3: output registers; they hold while the result is stalled downstream.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s3_prd_r <= '0;
            s3_sum_r <= '0;
        end else if (s3_en_s && s2_v_r) begin
            for (int k = 0; k < LANES; k++) begin
                s3_prd_r[k*PRD_W +: PRD_W] <= s2_prd_r[k];
            end
            s3_sum_r <= sum_s;
        end
    end

endmodule

// File: tb/tb_mul_fp_vec_pipe.sv
// Self-checking bench for mul_fp_vec_pipe: a default 4-lane instance and a
// small EXP_W=2/MAN_W=1/LANES=1 instance, both checked against a value-level
// reference model (decoded operand values multiplied as integers).
module tb_mul_fp_vec_pipe;

    localparam int LANES = 4;
    localparam int MPRD  = 42;
    localparam int MSUM  = 45;
    localparam int SPRD  = 14;
    localparam int SSUM  = 15;
`ifdef MUL_FP_VEC_PIPE_FTZ_EN
    localparam bit FTZ = 1'b1;
`else
    localparam bit FTZ = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  i_valid, o_ready, o_valid, i_ready;
    logic [LANES*8-1:0]    i_op0, i_op1;
    logic [LANES*MPRD-1:0] o_prd;
    logic [MSUM-1:0]       o_sum;
    logic                  s_valid, s_oready, s_ovalid, s_iready;
    logic [3:0]            s_op0, s_op1;
    logic [SPRD-1:0]       s_prd;
    logic [SSUM-1:0]       s_sum;

    int     n_assert = 0;
    int     n_fail   = 0;
    longint m_q[$];
    longint s_q[$];
    bit     m_acc, s_acc, m_blk;

    always #5 clk = ~clk;

    mul_fp_vec_pipe dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op0(i_op0), .i_op1(i_op1), .o_valid(o_valid), .i_ready(i_ready),
        .o_prd(o_prd), .o_sum(o_sum)
    );

    mul_fp_vec_pipe #(.EXP_W(2), .MAN_W(1), .LANES(1)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .o_ready(s_oready),
        .i_op0(s_op0), .i_op1(s_op1), .o_valid(s_ovalid), .i_ready(s_iready),
        .o_prd(s_prd), .o_sum(s_sum)
    );

    // Real value of a code: normal (2^mw + m) * 2^(e-1), subnormal m, sign applied.
    function automatic longint fp_val(input int unsigned code, input int ew, input int mw);
        int unsigned s, e, m;
        longint      mag;
        s = (code >> (ew + mw)) & 1;
        e = (code >> mw) & ((1 << ew) - 1);
        m = code & ((1 << mw) - 1);
        if (e == 0) mag = FTZ ? 64'sd0 : longint'(m);
        else        mag = ((longint'(1) << mw) + longint'(m)) * (longint'(1) << (e - 1));
        return (s != 0) ? -mag : mag;
    endfunction

    function automatic longint m_lane(input int k);
        return longint'($signed(o_prd[k*MPRD +: MPRD]));
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle for both DUTs; inputs are already driven at the current negedge.
    task automatic cycle();
        int     infl;
        longint p, sum;
        #1;
        infl = m_q.size() / (LANES + 1);
        chk("m_ready", longint'(o_ready), longint'(!(infl == 3 && !i_ready)));
        chk("m_spurious", longint'(o_valid && m_q.size() == 0), 0);
        if (!o_ready) m_blk = 1'b1;
        if (o_valid && m_q.size() != 0) begin
            for (int k = 0; k < LANES; k++) chk($sformatf("m_prd%0d", k), m_lane(k), m_q[k]);
            chk("m_sum", longint'($signed(o_sum)), m_q[LANES]);
            if (i_ready) repeat (LANES + 1) void'(m_q.pop_front());
        end
        m_acc = i_valid && o_ready;
        if (m_acc) begin
            sum = 0;
            for (int k = 0; k < LANES; k++) begin
                p = fp_val(i_op0[k*8 +: 8], 4, 3) * fp_val(i_op1[k*8 +: 8], 4, 3);
                m_q.push_back(p);
                sum += p;
            end
            m_q.push_back(sum);
        end
        infl = s_q.size() / 2;
        chk("s_ready", longint'(s_oready), longint'(!(infl == 3 && !s_iready)));
        chk("s_spurious", longint'(s_ovalid && s_q.size() == 0), 0);
        if (s_ovalid && s_q.size() != 0) begin
            chk($sformatf("s_prd %0d", s_q[0]), longint'($signed(s_prd)), s_q[0]);
            chk("s_sum", longint'($signed(s_sum)), s_q[1]);
            if (s_iready) repeat (2) void'(s_q.pop_front());
        end
        s_acc = s_valid && s_oready;
        if (s_acc) begin
            p = fp_val(s_op0, 2, 1) * fp_val(s_op1, 2, 1);
            s_q.push_back(p);
            s_q.push_back(p);
        end
        @(negedge clk);
    endtask

    initial begin
        int acc_n;
        int n;
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_op0 = '0; i_op1 = '0;
        s_valid = 1'b0; s_iready = 1'b1; s_op0 = '0; s_op1 = '0; m_blk = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hold_valid", longint'(o_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", longint'(o_valid), 0);
        chk("rst_prd_zero", longint'(o_prd == '0), 1);
        chk("rst_sum", longint'($signed(o_sum)), 0);
        chk("rst_ready", longint'(o_ready), 1);
        chk("rst_s_ready", longint'(s_oready), 1);

        // all lanes 0x38 x 0x38, latency exactly three cycles
        i_op0 = {LANES{8'h38}}; i_op1 = {LANES{8'h38}}; i_valid = 1'b1;
        cycle();
        chk("d1_accept", longint'(m_acc), 1);
        i_valid = 1'b0;
        chk("d1_lat1", longint'(o_valid), 0);
        cycle();
        chk("d1_lat2", longint'(o_valid), 0);
        cycle();
        chk("d1_lat3", longint'(o_valid), 1);
        chk("d1_prd0", m_lane(0), 64'sd262144);
        chk("d1_prd3", m_lane(3), 64'sd262144);
        chk("d1_sum", longint'($signed(o_sum)), 64'sd1048576);
        cycle();

        // mixed signs, subnormal, maximum magnitude and zero
        i_op0 = {8'h00, 8'h7F, 8'h01, 8'hB8}; i_op1 = {8'h7F, 8'h7F, 8'h01, 8'h38}; i_valid = 1'b1;
        cycle();
        i_valid = 1'b0;
        cycle();
        cycle();
        chk("d2_prd0", m_lane(0), -64'sd262144);
        chk("d2_prd1", m_lane(1), FTZ ? 64'sd0 : 64'sd1);
        chk("d2_prd2", m_lane(2), 64'sd60397977600);
        chk("d2_prd3", m_lane(3), 64'sd0);
        chk("d2_sum", longint'($signed(o_sum)), FTZ ? 64'sd60397715456 : 64'sd60397715457);
        cycle();

        // subnormal times normal
        i_op0 = {LANES{8'h01}}; i_op1 = {LANES{8'h38}}; i_valid = 1'b1;
        cycle();
        i_valid = 1'b0;
        cycle();
        cycle();
        chk("d3_prd0", m_lane(0), FTZ ? 64'sd0 : 64'sd512);
        chk("d3_sum", longint'($signed(o_sum)), FTZ ? 64'sd0 : 64'sd2048);
        cycle();

        // backpressure: six vectors, i_ready low for five cycles starting at cycle 2
        acc_n = 0; m_blk = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (acc_n >= 6 && m_q.size() == 0) break;
            i_valid = (acc_n < 6);
            i_op0 = $urandom; i_op1 = $urandom;
            i_ready = !(t >= 2 && t < 7);
            cycle();
            if (m_acc) acc_n++;
        end
        chk("bp_accepted", longint'(acc_n), 6);
        chk("bp_drained", longint'(m_q.size()), 0);
        chk("bp_blocked", longint'(m_blk), 1);

        // reset with two vectors in flight, the oldest already at the output
        i_valid = 1'b1; i_ready = 1'b0; i_op0 = {LANES{8'h38}}; i_op1 = {LANES{8'h38}};
        cycle();
        cycle();
        i_valid = 1'b0;
        cycle();
        chk("rm_pre_valid", longint'(o_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rm_valid", longint'(o_valid), 0);
        chk("rm_prd_zero", longint'(o_prd == '0), 1);
        chk("rm_sum", longint'($signed(o_sum)), 0);
        m_q.delete();
        s_q.delete();
        @(negedge clk);
        rst_n = 1'b1; i_ready = 1'b1;
        repeat (6) cycle();
        chk("rm_post_ready", longint'(o_ready), 1);

        // random valid/ready/operands on the default instance
        for (int t = 0; t < 120; t++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_op0 = $urandom; i_op1 = $urandom;
            cycle();
        end
        i_valid = 1'b0; i_ready = 1'b1;
        repeat (5) cycle();
        chk("rnd_drained", longint'(m_q.size()), 0);

        // small instance: all 256 operand pairs under random backpressure
        n = 0;
        for (int t = 0; t < 3000; t++) begin
            if (n >= 256 && s_q.size() == 0) break;
            s_valid = (n < 256);
            s_op0 = n[7:4]; s_op1 = n[3:0];
            s_iready = ($urandom_range(0, 3) != 0);
            cycle();
            if (s_acc) n++;
        end
        chk("small_accepted", longint'(n), 256);
        chk("small_drained", longint'(s_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
